fft_ctrl: RTL and testbench
===========================

FFT_CTRL -- requirements
Module: fft_ctrl

Interface
REQ-001 SHALL have parameter N_LOG2, default 8: log2 of FFT length N (N = 2^N_LOG2, N/2 butterflies per stage).
REQ-002 SHALL have parameter RD_LAT, default 1: cycles from data-RAM and twiddle-ROM address to data.
REQ-003 SHALL have parameter BF_LAT, default 3: cycles from butterfly en to its registered outputs.
REQ-004 SHALL have port clk, input, 1, clock; all logic on the rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, single-cycle request to run one FFT.
REQ-007 SHALL have port busy, output, 1, high from the cycle after start is accepted until done.
REQ-008 SHALL have port done, output, 1, one-cycle pulse at completion.
REQ-009 SHALL have port stage, output, N_LOG2 bits wide enough for 0..N_LOG2-1, current stage index.
REQ-010 SHALL have port rd_en, output, 1, data-RAM read strobe.
REQ-011 SHALL have ports rd_addr_a and rd_addr_b, output, N_LOG2 each, butterfly operand addresses.
REQ-012 SHALL have port tw_addr, output, N_LOG2-1, twiddle-ROM address, valid with rd_en.
REQ-013 SHALL have port bf_en, output, 1, butterfly enable (rd_en delayed RD_LAT).
REQ-014 SHALL have port wr_en, output, 1, data-RAM write strobe (rd_en delayed RD_LAT+BF_LAT).
REQ-015 SHALL have ports wr_addr_a and wr_addr_b, output, N_LOG2 each, in-place write-back addresses.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DRAIN, DONE; reset state IDLE.
REQ-017 SHALL, in IDLE with start=1, go to RUN with stage=0 and butterfly counter k=0.
REQ-018 SHALL ignore start in every state other than IDLE.
REQ-019 SHALL, in RUN, assert rd_en every cycle and issue one butterfly per cycle, k = 0..N/2-1.
REQ-020 SHALL compute, with half = 2^stage, pos = k mod half and grp = k div half: rd_addr_a = 2*half*grp + pos, rd_addr_b = rd_addr_a + half, tw_addr = pos shifted left by (N_LOG2-1-stage).
REQ-021 SHALL go from RUN to DRAIN after issuing k = N/2-1.
REQ-022 SHALL hold DRAIN until the last wr_en of the stage has fired, so the next stage's first rd_en occurs exactly one cycle after that last wr_en (no read-after-write hazard).
REQ-023 SHALL, when leaving DRAIN, increment stage and return to RUN with k=0 if stage < N_LOG2-1; otherwise go to DONE.
REQ-024 SHALL make each stage occupy exactly N/2 + RD_LAT + BF_LAT cycles.
REQ-025 SHALL generate bf_en, wr_en, wr_addr_a and wr_addr_b through shift-register delay lines of rd_en, rd_addr_a and rd_addr_b; these SHALL never be recomputed.
REQ-026 SHALL, in DONE, pulse done for one cycle, deassert busy in the same cycle, and return to IDLE.
REQ-027 SHALL drive rd_en, bf_en and wr_en low and hold the address outputs at their last value whenever the corresponding strobe is low.
REQ-028 SHALL leave bit-reversed input ordering and data scaling outside this block.

Reset
REQ-029 SHALL, on rst low, force all outputs, counters, delay lines and the FSM to 0/IDLE immediately, including mid-FFT; no write SHALL follow the reset.
REQ-030 SHALL accept a new start on the first cycle after rst deasserts.

Structure
REQ-031 SHALL place the FSM state encoding and default N_LOG2, RD_LAT and BF_LAT in a shared package fft_pkg.
REQ-032 SHALL implement the delay lines in one sub-module, fft_delay_line (parameterised width and depth), instantiated for strobes and write addresses.

Verification
REQ-033 SHALL check, with N_LOG2=3, stage 1: (a,b,tw) = (0,2,0), (1,3,2), (4,6,0), (5,7,2).
REQ-034 SHALL check, with N_LOG2=3, stage 2: a=k, b=k+4, tw=k for k=0..3; stage 0: (0,1,0), (2,3,0), (4,5,0), (6,7,0).
REQ-035 SHALL check, with N_LOG2=8 defaults and start sampled at cycle 0: first rd_en at cycle 1, final wr_en at cycle 1056, done at cycle 1057, busy high on cycles 1-1056.
REQ-036 SHALL check that every wr_en occurs 4 cycles after its rd_en with identical addresses, and bf_en 1 cycle after it.
REQ-037 SHALL check that start pulsed at cycle 50 of a run causes no change in the schedule or the done time.
REQ-038 SHALL check that rst asserted at cycle 300 gives all outputs 0 within that cycle, no further wr_en, and that a new start runs a full correct FFT.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT address/sequence controller.
// Contents: default FFT size and pipeline latencies, and the FSM state encoding.
package fft_pkg;

  localparam int N_LOG2_DEF = 8;
  localparam int RD_LAT_DEF = 1;
  localparam int BF_LAT_DEF = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fft_state_t;

endpackage

// File: rtl/fft_delay_line.sv
// Fixed-depth shift-register delay line with asynchronous active-low clear.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset, clears every tap
//   din  - WIDTH-bit input
//   dout - din delayed by DEPTH cycles (combinational pass-through when DEPTH is 0)
module fft_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign dout = din;
    end else begin : g_shift
      logic [WIDTH-1:0] taps [DEPTH];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
        end else begin
          taps[0] <= din;
          for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
        end
      end

      assign dout = taps[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/fft_ctrl.sv
// In-place radix-2 FFT sequencer: issues one butterfly per cycle, stage by stage,
// with data-RAM/twiddle-ROM addressing and delayed butterfly/write-back strobes.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing butterflies k = 0..N/2-1 of the current stage
// DRAIN | waiting for the stage's last write-back before the next stage reads
// DONE  | one-cycle completion pulse, then back to IDLE
//
// Ports:
//   clk, rst              - clock (rising edge), async active-low reset
//   start                 - one-cycle run request, honoured only in IDLE
//   busy, done            - run in progress / completion pulse
//   stage                 - current stage index
//   rd_en, rd_addr_a/b    - data-RAM read strobe and operand addresses
//   tw_addr               - twiddle-ROM address, valid with rd_en
//   bf_en                 - butterfly enable, rd_en delayed RD_LAT
//   wr_en, wr_addr_a/b    - write-back strobe and addresses, delayed RD_LAT+BF_LAT
module fft_ctrl
  import fft_pkg::*;
#(
  parameter int N_LOG2 = N_LOG2_DEF,
  parameter int RD_LAT = RD_LAT_DEF,
  parameter int BF_LAT = BF_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [N_LOG2-1:0] stage,
  output logic              rd_en,
  output logic [N_LOG2-1:0] rd_addr_a,
  output logic [N_LOG2-1:0] rd_addr_b,
  output logic [N_LOG2-2:0] tw_addr,
  output logic              bf_en,
  output logic              wr_en,
  output logic [N_LOG2-1:0] wr_addr_a,
  output logic [N_LOG2-1:0] wr_addr_b
);

  localparam int KW        = N_LOG2 - 1;
  localparam int DRAIN_LEN = RD_LAT + BF_LAT;
  localparam int DW        = (DRAIN_LEN < 2) ? 1 : $clog2(DRAIN_LEN);

  localparam logic [KW-1:0]     K_LAST     = '1;
  localparam logic [N_LOG2-1:0] STAGE_LAST = N_LOG2'(N_LOG2 - 1);
  localparam logic [DW-1:0]     DRAIN_LD   = DW'(DRAIN_LEN - 1);

  fft_state_t        state, state_nxt;
  logic [N_LOG2-1:0] stage_nxt;
  logic [KW-1:0]     k_q, k_nxt;
  logic [DW-1:0]     drain_cnt, drain_nxt;

  // Operand A: insert a zero at bit position st of k, i.e. 2*half*grp + pos.
  function automatic logic [N_LOG2-1:0] addr_a_f(input logic [N_LOG2-1:0] st,
                                                 input logic [KW-1:0]     k);
    logic [N_LOG2-1:0] kx;
    logic [N_LOG2-1:0] low_mask;
    kx       = {1'b0, k};
    low_mask = (N_LOG2'(1) << st) - N_LOG2'(1);
    return ((kx & ~low_mask) << 1) | (kx & low_mask);
  endfunction

  function automatic logic [KW-1:0] tw_f(input logic [N_LOG2-1:0] st,
                                         input logic [KW-1:0]     k);
    logic [N_LOG2-1:0] low_mask;
    logic [N_LOG2-1:0] pos_sh;
    low_mask = (N_LOG2'(1) << st) - N_LOG2'(1);
    pos_sh   = ({1'b0, k} & low_mask) << (N_LOG2'(KW) - st);
    return pos_sh[KW-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      stage     <= '0;
      k_q       <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      stage     <= stage_nxt;
      k_q       <= k_nxt;
      drain_cnt <= drain_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    stage_nxt = stage;
    k_nxt     = k_q;
    drain_nxt = drain_cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          stage_nxt = '0;
          k_nxt     = '0;
        end
      end
      RUN: begin
        if (k_q == K_LAST) begin
          state_nxt = DRAIN;
          drain_nxt = DRAIN_LD;
        end else begin
          k_nxt = k_q + KW'(1);
        end
      end
      DRAIN: begin
        // Count reaches zero on the cycle of the stage's last wr_en.
        if (drain_cnt == '0) begin
          if (stage == STAGE_LAST) begin
            state_nxt = DONE;
          end else begin
            state_nxt = RUN;
            stage_nxt = stage + N_LOG2'(1);
            k_nxt     = '0;
          end
        end else begin
          drain_nxt = drain_cnt - DW'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read side is registered from next-state values so rd_en lines up with RUN
  // and the addresses only move when a new butterfly is issued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;
    end else begin
      rd_en <= (state_nxt == RUN);
      if (state_nxt == RUN) begin
        rd_addr_a <= addr_a_f(stage_nxt, k_nxt);
        rd_addr_b <= addr_a_f(stage_nxt, k_nxt) | (N_LOG2'(1) << stage_nxt);
        tw_addr   <= tw_f(stage_nxt, k_nxt);
      end
    end
  end

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);

  fft_delay_line #(.WIDTH(1), .DEPTH(RD_LAT)) u_dl_bf (
    .clk  (clk),
    .rst  (rst),
    .din  (rd_en),
    .dout (bf_en)
  );

  fft_delay_line #(.WIDTH(1), .DEPTH(BF_LAT)) u_dl_wr (
    .clk  (clk),
    .rst  (rst),
    .din  (bf_en),
    .dout (wr_en)
  );

  // Addresses only change while rd_en is high, so the delayed copies likewise
  // only change on wr_en cycles and hold their last value otherwise.
  fft_delay_line #(.WIDTH(2 * N_LOG2), .DEPTH(DRAIN_LEN)) u_dl_addr (
    .clk  (clk),
    .rst  (rst),
    .din  ({rd_addr_a, rd_addr_b}),
    .dout ({wr_addr_a, wr_addr_b})
  );

endmodule

// File: tb/tb_fft_ctrl.sv
// Self-checking bench for fft_ctrl: a default-size instance (N_LOG2=8) for
// schedule, latency, start-ignore and mid-run reset, and an N_LOG2=3 instance
// for addressing against literal tables.
module tb_fft_ctrl;

  localparam int LAST_WR = 1056;
  localparam int DONE_AT = 1057;

  logic clk = 1'b0;
  logic rst;
  logic start8, start3;

  logic       busy8, done8, rd_en8, bf_en8, wr_en8;
  logic [7:0] stage8, rd_addr_a8, rd_addr_b8, wr_addr_a8, wr_addr_b8;
  logic [6:0] tw_addr8;

  logic       busy3, done3, rd_en3, bf_en3, wr_en3;
  logic [2:0] stage3, rd_addr_a3, rd_addr_b3, wr_addr_a3, wr_addr_b3;
  logic [1:0] tw_addr3;

  logic [51:0] outs8;
  logic [22:0] outs3;

  typedef struct { int a; int b; int tw; int st; } rd_exp_t;
  typedef struct { int a; int b; int t; } wr_exp_t;

  rd_exp_t rd_q[$];
  rd_exp_t q3[$];
  wr_exp_t wr_q[$];
  int      bf_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t0       = 0;
  bit mon_on   = 1'b0;
  bit full_run = 1'b0;
  int first_rd, last_wr, done_rel;

  int      mrel;
  rd_exp_t m_e;
  wr_exp_t m_w;
  int      m_t;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fft_ctrl u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .start     (start8),
    .busy      (busy8),
    .done      (done8),
    .stage     (stage8),
    .rd_en     (rd_en8),
    .rd_addr_a (rd_addr_a8),
    .rd_addr_b (rd_addr_b8),
    .tw_addr   (tw_addr8),
    .bf_en     (bf_en8),
    .wr_en     (wr_en8),
    .wr_addr_a (wr_addr_a8),
    .wr_addr_b (wr_addr_b8)
  );

  fft_ctrl #(.N_LOG2(3)) u_dut3 (
    .clk       (clk),
    .rst       (rst),
    .start     (start3),
    .busy      (busy3),
    .done      (done3),
    .stage     (stage3),
    .rd_en     (rd_en3),
    .rd_addr_a (rd_addr_a3),
    .rd_addr_b (rd_addr_b3),
    .tw_addr   (tw_addr3),
    .bf_en     (bf_en3),
    .wr_en     (wr_en3),
    .wr_addr_a (wr_addr_a3),
    .wr_addr_b (wr_addr_b3)
  );

  assign outs8 = {busy8, done8, rd_en8, bf_en8, wr_en8, stage8, rd_addr_a8, rd_addr_b8,
                  tw_addr8, wr_addr_a8, wr_addr_b8};
  assign outs3 = {busy3, done3, rd_en3, bf_en3, wr_en3, stage3, rd_addr_a3, rd_addr_b3,
                  tw_addr3, wr_addr_a3, wr_addr_b3};

  task automatic check_val(input string tag, input longint obs, input longint exp_v);
    n_checks++;
    if (obs != exp_v) begin
      n_fail++;
      $display("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Scoreboard monitor for the N_LOG2=8 instance.
  always @(negedge clk) begin
    if (mon_on) begin
      mrel = cyc - t0;
      if (full_run) check_val("busy", busy8, (mrel >= 1 && mrel <= LAST_WR));
      if (rd_en8) begin
        if (first_rd < 0) first_rd = mrel;
        if (rd_q.size() == 0) begin
          check_val("rd_unexpected", 1, 0);
        end else begin
          m_e = rd_q.pop_front();
          check_val("rd_addr_a", rd_addr_a8, m_e.a);
          check_val("rd_addr_b", rd_addr_b8, m_e.b);
          check_val("tw_addr", tw_addr8, m_e.tw);
          check_val("stage", stage8, m_e.st);
          wr_q.push_back('{m_e.a, m_e.b, mrel});
          bf_q.push_back(mrel);
        end
      end
      if (bf_en8) begin
        if (bf_q.size() == 0) begin
          check_val("bf_unexpected", 1, 0);
        end else begin
          m_t = bf_q.pop_front();
          check_val("bf_lat", mrel - m_t, 1);
        end
      end
      if (wr_en8) begin
        if (wr_q.size() == 0) begin
          check_val("wr_unexpected", 1, 0);
        end else begin
          m_w = wr_q.pop_front();
          check_val("wr_lat", mrel - m_w.t, 4);
          check_val("wr_addr_a", wr_addr_a8, m_w.a);
          check_val("wr_addr_b", wr_addr_b8, m_w.b);
        end
        last_wr = mrel;
      end
      if (done8 && done_rel < 0) done_rel = mrel;
    end
  end

  task automatic run8(input bit pulse50, input int rst_at);
    int  rel;
    bit  stop;
    int  half;
    rd_q.delete();
    wr_q.delete();
    bf_q.delete();
    first_rd = -1;
    last_wr  = -1;
    done_rel = -1;
    for (int s = 0; s < 8; s++) begin
      for (int k = 0; k < 128; k++) begin
        half = 1 << s;
        rd_q.push_back('{2 * half * (k / half) + (k % half),
                         2 * half * (k / half) + (k % half) + half,
                         (k % half) * (1 << (7 - s)), s});
      end
    end
    full_run = (rst_at < 0);
    @(negedge clk);
    rst    = 1'b1;
    t0     = cyc;
    start8 = 1'b1;
    mon_on = 1'b1;
    stop   = 1'b0;
    while (!stop) begin
      @(negedge clk);
      rel    = cyc - t0;
      start8 = pulse50 && (rel == 50);
      if (rst_at >= 0 && rel == rst_at) begin
        rst    = 1'b0;
        mon_on = 1'b0;
        #1;
        check_val("rst_mid_outputs", outs8, 0);
        repeat (10) begin
          @(negedge clk);
          check_val("wr_after_rst", wr_en8, 0);
          check_val("busy_after_rst", busy8, 0);
        end
        stop = 1'b1;
      end else if (rel >= DONE_AT + 5) begin
        stop = 1'b1;
      end
    end
    if (full_run) begin
      mon_on = 1'b0;
      check_val("first_rd_cycle", first_rd, 1);
      check_val("last_wr_cycle", last_wr, LAST_WR);
      check_val("done_cycle", done_rel, DONE_AT);
      check_val("rd_left", rd_q.size(), 0);
      check_val("wr_left", wr_q.size(), 0);
    end
  endtask

  task automatic run3();
    int      tab_a [12];
    int      tab_b [12];
    int      tab_tw[12];
    int      rel, n_wr, d_rel;
    rd_exp_t e;
    tab_a  = '{0, 2, 4, 6,  0, 2, 4, 6,  0, 1, 2, 3};
    tab_b  = '{1, 3, 5, 7,  1, 3, 5, 7,  4, 5, 6, 7};
    tab_tw = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};
    // stage 1 pairs are (0,2),(1,3),(4,6),(5,7)
    tab_a[4] = 0; tab_a[5] = 1; tab_a[6] = 4; tab_a[7] = 5;
    tab_b[4] = 2; tab_b[5] = 3; tab_b[6] = 6; tab_b[7] = 7;
    q3.delete();
    for (int i = 0; i < 12; i++) q3.push_back('{tab_a[i], tab_b[i], tab_tw[i], i / 4});
    n_wr  = 0;
    d_rel = -1;
    @(negedge clk);
    t0     = cyc;
    start3 = 1'b1;
    for (int i = 0; i < 40 && d_rel < 0; i++) begin
      @(negedge clk);
      start3 = 1'b0;
      rel    = cyc - t0;
      if (rd_en3) begin
        if (q3.size() == 0) begin
          check_val("n3_rd_unexpected", 1, 0);
        end else begin
          e = q3.pop_front();
          check_val("n3_rd_addr_a", rd_addr_a3, e.a);
          check_val("n3_rd_addr_b", rd_addr_b3, e.b);
          check_val("n3_tw_addr", tw_addr3, e.tw);
          check_val("n3_stage", stage3, e.st);
        end
      end
      if (wr_en3) n_wr++;
      if (done3) d_rel = rel;
    end
    check_val("n3_done_cycle", d_rel, 25);
    check_val("n3_wr_count", n_wr, 12);
    check_val("n3_rd_left", q3.size(), 0);
  endtask

  initial begin
    rst    = 1'b0;
    start8 = 1'b0;
    start3 = 1'b0;
    repeat (3) @(negedge clk);
    check_val("reset_outputs8", outs8, 0);
    check_val("reset_outputs3", outs3, 0);
    @(negedge clk);
    rst = 1'b1;
    run3();
    run8(1'b1, -1);
    run8(1'b0, 300);
    run8(1'b0, -1);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
